// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the four requesting agents and the round-robin arbiter.
// The master side drives requests; the slave side (the arbiter) returns the registered grant.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic [7:0] burst_cnt;

  modport master (output req, input gnt_idx, gnt_valid, burst_cnt);
  modport slave  (input req, output gnt_idx, gnt_valid, burst_cnt);
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded burst length; registered 2-bit grant
// index plus qualifier and burst counter, feeding the downstream 2-to-4 grant decoder.
module rr_arbiter4 #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter4_if.slave arb
);

  localparam logic [7:0] MAXB = 8'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [7:0] burst_q, burst_d;

  logic [1:0] search_base;
  logic [1:0] cand;
  logic [1:0] win_idx;
  logic       win_found;
  logic       release_now;

  // On release the pointer becomes owner+1, so the search already starts there this cycle.
  always_comb begin
    search_base = (state_q == GRANT) ? gnt_idx_q + 2'd1 : ptr_q;
    win_idx     = search_base;
    win_found   = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = search_base + 2'(i);
      if (!win_found && arb.req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  assign release_now = !arb.req[gnt_idx_q] || (burst_q == MAXB);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    burst_d     = burst_q;
    unique case (state_q)
      IDLE: begin
        gnt_valid_d = 1'b0;
        if (win_found) begin
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          burst_d     = 8'd1;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!release_now) begin
          burst_d = burst_q + 8'd1;
        end else begin
          ptr_d = gnt_idx_q + 2'd1;
          if (win_found) begin
            gnt_idx_d   = win_idx;
            gnt_valid_d = 1'b1;
            burst_d     = 8'd1;
          end else begin
            gnt_valid_d = 1'b0;
            burst_d     = '0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      burst_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      burst_q     <= burst_d;
    end
  end

  assign arb.gnt_idx   = gnt_idx_q;
  assign arb.gnt_valid = gnt_valid_q;
  assign arb.burst_cnt = burst_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: three instances (MAX_BURST 8, 2, 1) share one request
// vector; a behavioural model predicts each edge and a monitor compares after every edge.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;

  rr_arbiter4_if if8 ();
  rr_arbiter4_if if2 ();
  rr_arbiter4_if if1 ();

  assign if8.req = req;
  assign if2.req = req;
  assign if1.req = req;

  rr_arbiter4 #(.MAX_BURST(8)) dut8 (.clk(clk), .rst(rst), .arb(if8.slave));
  rr_arbiter4 #(.MAX_BURST(2)) dut2 (.clk(clk), .rst(rst), .arb(if2.slave));
  rr_arbiter4 #(.MAX_BURST(1)) dut1 (.clk(clk), .rst(rst), .arb(if1.slave));

  always #5 clk = ~clk;

  logic [1:0] a_idx [3];
  logic       a_v   [3];
  logic [7:0] a_cnt [3];
  assign a_idx[0] = if8.gnt_idx;  assign a_v[0] = if8.gnt_valid;  assign a_cnt[0] = if8.burst_cnt;
  assign a_idx[1] = if2.gnt_idx;  assign a_v[1] = if2.gnt_valid;  assign a_cnt[1] = if2.burst_cnt;
  assign a_idx[2] = if1.gnt_idx;  assign a_v[2] = if1.gnt_valid;  assign a_cnt[2] = if1.burst_cnt;

  typedef struct packed {
    logic [2:0][1:0] idx;
    logic [2:0]      v;
    logic [2:0][7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   started  = 0;

  // Reference model: owner index, owner valid, cycles held, next search start.
  int m_idx [3];
  bit m_v   [3];
  int m_cnt [3];
  int m_ptr [3];
  int mb    [3] = '{8, 2, 1};

  task automatic chk(input string name, input int inst, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got %0d expected %0d", name, inst, $time, actual, expected);
    end
  endtask

  function automatic int search(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_idx[i] = 0; m_v[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    for (int i = 0; i < 3; i++) begin
      if (!m_v[i]) begin
        w = search(r, m_ptr[i]);
        if (w >= 0) begin
          m_idx[i] = w; m_v[i] = 1; m_cnt[i] = 1;
        end
      end else if (r[m_idx[i]] && m_cnt[i] < mb[i]) begin
        m_cnt[i]++;
      end else begin
        m_ptr[i] = (m_idx[i] + 1) % 4;
        w = search(r, m_ptr[i]);
        if (w >= 0) begin
          m_idx[i] = w; m_cnt[i] = 1;
        end else begin
          m_v[i] = 0; m_cnt[i] = 0;
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, predict the state after the next rising edge.
  task automatic cycle(input logic [3:0] r, input logic rst_v);
    exp_t e;
    @(negedge clk);
    req = r;
    rst = rst_v;
    if (rst_v) model_reset();
    else       model_step(r);
    for (int i = 0; i < 3; i++) begin
      e.idx[i] = 2'(m_idx[i]);
      e.v[i]   = m_v[i];
      e.cnt[i] = 8'(m_cnt[i]);
    end
    q.push_back(e);
    started = 1;
  endtask

  task automatic run(input logic [3:0] r, input int n);
    for (int k = 0; k < n; k++) cycle(r, 1'b0);
  endtask

  // Reset asserted between edges must clear every output without a clock.
  task automatic async_reset(input logic [3:0] r_hold);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_rst_valid", i, int'(a_v[i]),   0);
      chk("async_rst_idx",   i, int'(a_idx[i]), 0);
      chk("async_rst_cnt",   i, int'(a_cnt[i]), 0);
    end
    model_reset();
    cycle(r_hold, 1'b1);
    cycle(r_hold, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (started) chk("scoreboard_underflow", 0, 0, 1);
      end else begin
        e = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk("gnt_valid", i, int'(a_v[i]), int'(e.v[i]));
          chk("gnt_idx",   i, int'(a_idx[i]), int'(e.idx[i]));
          chk("burst_cnt", i, int'(a_cnt[i]), int'(e.cnt[i]));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [3:0] r;
    int         hold;
    model_reset();
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("init_rst_valid", i, int'(a_v[i]),   0);
      chk("init_rst_idx",   i, int'(a_idx[i]), 0);
      chk("init_rst_cnt",   i, int'(a_cnt[i]), 0);
    end
    cycle(4'b0000, 1'b1);
    run(4'b0000, 5);
    run(4'b0100, 20);
    run(4'b0000, 2);
    run(4'b1001, 3);
    run(4'b1111, 12);
    run(4'b0000, 2);
    run(4'b0011, 3);
    run(4'b0010, 3);
    run(4'b0000, 1);
    run(4'b1000, 5);
    async_reset(4'b1111);
    run(4'b1111, 6);
    for (int t = 0; t < 120; t++) begin
      r    = 4'($urandom);
      hold = $urandom_range(1, 12);
      if ($urandom_range(0, 29) == 0) async_reset(r);
      run(r, hold);
    end
    run(4'b0000, 2);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 0, q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
